// File: rtl/asi_pkg.sv
// Shared AXI widths, burst/response encodings and the AXI master FSM state types.
package asi_pkg;

  localparam int AXI_IW     = 4;
  localparam int AXI_AW     = 32;
  localparam int AXI_LW     = 8;
  localparam int AXI_SW     = 3;
  localparam int AXI_BURSTW = 2;
  localparam int AXI_DW     = 64;
  localparam int AXI_WSTRBW = AXI_DW / 8;
  localparam int AXI_BRESPW = 2;
  localparam int AXI_RRESPW = 2;

  // Number of address bits below one full data beat.
  localparam int AXI_BYTE_LSB = $clog2(AXI_DW / 8);

  localparam logic [AXI_BURSTW-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BRESPW-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_BRESPW-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} ami_wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} ami_rstate_e;

  function automatic logic [AXI_AW-1:0] beat_align(input logic [AXI_AW-1:0] addr);
    return {addr[AXI_AW-1:AXI_BYTE_LSB], {AXI_BYTE_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/ami.sv
// Simple AXI burst master: one INCR write and one INCR read in flight, independent FSMs.
// Address phase precedes data; W/R data and handshakes pass straight through in the data states.
module ami
  import asi_pkg::*;
#(
  parameter logic [AXI_IW-1:0] MST_ID  = '0,
  parameter bit                SLV_CHK = 1'b1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  output logic [AXI_IW-1:0]     AWID,
  output logic [AXI_AW-1:0]     AWADDR,
  output logic [AXI_LW-1:0]     AWLEN,
  output logic [AXI_SW-1:0]     AWSIZE,
  output logic [AXI_BURSTW-1:0] AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [AXI_DW-1:0]     WDATA,
  output logic [AXI_WSTRBW-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [AXI_IW-1:0]     BID,
  input  logic [AXI_BRESPW-1:0] BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [AXI_IW-1:0]     ARID,
  output logic [AXI_AW-1:0]     ARADDR,
  output logic [AXI_LW-1:0]     ARLEN,
  output logic [AXI_SW-1:0]     ARSIZE,
  output logic [AXI_BURSTW-1:0] ARBURST,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [AXI_IW-1:0]     RID,
  input  logic [AXI_DW-1:0]     RDATA,
  input  logic [AXI_RRESPW-1:0] RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic                  u_wcmd_valid,
  output logic                  u_wcmd_ready,
  input  logic [AXI_AW-1:0]     u_wcmd_addr,
  input  logic [AXI_LW-1:0]     u_wcmd_len,
  input  logic                  u_wvalid,
  output logic                  u_wready,
  input  logic [AXI_DW-1:0]     u_wdata,
  input  logic [AXI_WSTRBW-1:0] u_wstrb,
  output logic                  u_wdone,
  output logic [AXI_BRESPW-1:0] u_wresp,
  input  logic                  u_rcmd_valid,
  output logic                  u_rcmd_ready,
  input  logic [AXI_AW-1:0]     u_rcmd_addr,
  input  logic [AXI_LW-1:0]     u_rcmd_len,
  output logic                  u_rvalid,
  input  logic                  u_rready,
  output logic [AXI_DW-1:0]     u_rdata,
  output logic [AXI_RRESPW-1:0] u_rresp,
  output logic                  u_rlast,
  output logic                  u_rerr
);

  ami_wstate_e       w_state, w_next;
  ami_rstate_e       r_state, r_next;
  logic [AXI_AW-1:0] w_addr, r_addr;
  logic [AXI_LW-1:0] w_len, r_len, w_cnt, r_cnt;
  logic              w_hs, r_hs, r_at_end;

  // IDs of returning responses are not used: only one transaction per direction is ever open.
  logic unused_ids;
  assign unused_ids = ^{BID, RID};

  assign AWID    = MST_ID;
  assign AWADDR  = w_addr;
  assign AWLEN   = w_len;
  assign AWSIZE  = AXI_SW'(AXI_BYTE_LSB);
  assign AWBURST = BURST_INCR;
  assign ARID    = MST_ID;
  assign ARADDR  = r_addr;
  assign ARLEN   = r_len;
  assign ARSIZE  = AXI_SW'(AXI_BYTE_LSB);
  assign ARBURST = BURST_INCR;
  assign WDATA   = u_wdata;
  assign WSTRB   = u_wstrb;
  assign u_rdata = RDATA;
  assign u_rresp = RRESP;
  assign u_rlast = RLAST;

  assign w_hs     = WVALID && WREADY;
  assign r_hs     = RVALID && RREADY;
  assign r_at_end = (r_cnt == r_len);

  always_comb begin
    w_next       = w_state;
    u_wcmd_ready = 1'b0;
    AWVALID      = 1'b0;
    WVALID       = 1'b0;
    WLAST        = 1'b0;
    u_wready     = 1'b0;
    BREADY       = 1'b0;
    case (w_state)
      W_IDLE: begin
        u_wcmd_ready = 1'b1;
        if (u_wcmd_valid) w_next = W_ADDR;
      end
      W_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) w_next = W_DATA;
      end
      W_DATA: begin
        WVALID   = u_wvalid;
        u_wready = WREADY;
        WLAST    = (w_cnt == w_len);
        if (u_wvalid && WREADY && WLAST) w_next = W_RESP;
      end
      W_RESP: begin
        BREADY = 1'b1;
        if (BVALID) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next       = r_state;
    u_rcmd_ready = 1'b0;
    ARVALID      = 1'b0;
    RREADY       = 1'b0;
    u_rvalid     = 1'b0;
    case (r_state)
      R_IDLE: begin
        u_rcmd_ready = 1'b1;
        if (u_rcmd_valid) r_next = R_ADDR;
      end
      R_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) r_next = R_DATA;
      end
      R_DATA: begin
        RREADY   = u_rready;
        u_rvalid = RVALID;
        if (RVALID && u_rready && RLAST) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      u_wdone <= 1'b0;
      u_wresp <= '0;
    end else begin
      w_state <= w_next;
      u_wdone <= (w_state == W_RESP) && BVALID;
      if ((w_state == W_RESP) && BVALID) u_wresp <= BRESP;
      if ((w_state == W_IDLE) && u_wcmd_valid) begin
        w_addr <= beat_align(u_wcmd_addr);
        w_len  <= u_wcmd_len;
      end
      if (w_hs) w_cnt <= WLAST ? '0 : w_cnt + AXI_LW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      u_rerr  <= 1'b0;
    end else begin
      r_state <= r_next;
      if ((r_state == R_IDLE) && u_rcmd_valid) begin
        r_addr <= beat_align(u_rcmd_addr);
        r_len  <= u_rcmd_len;
      end
      if (r_hs) r_cnt <= RLAST ? '0 : r_cnt + AXI_LW'(1);
      // Early RLAST, or a final beat without RLAST, marks the slave as misbehaving until reset.
      if (SLV_CHK && r_hs && (RLAST != r_at_end)) u_rerr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ami.sv
// Directed bench for the ami AXI master: a hand-driven slave and user side, inline checks per scenario.
module tb_ami;
  import asi_pkg::*;

  localparam logic [AXI_IW-1:0] TB_ID = 4'h5;

  logic                  ACLK, ARESET;
  logic [AXI_IW-1:0]     AWID, ARID, BID, RID;
  logic [AXI_AW-1:0]     AWADDR, ARADDR, u_wcmd_addr, u_rcmd_addr;
  logic [AXI_LW-1:0]     AWLEN, ARLEN, u_wcmd_len, u_rcmd_len;
  logic [AXI_SW-1:0]     AWSIZE, ARSIZE;
  logic [AXI_BURSTW-1:0] AWBURST, ARBURST;
  logic                  AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic                  ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [AXI_DW-1:0]     WDATA, RDATA, u_wdata, u_rdata;
  logic [AXI_WSTRBW-1:0] WSTRB, u_wstrb;
  logic [AXI_BRESPW-1:0] BRESP, u_wresp;
  logic [AXI_RRESPW-1:0] RRESP, u_rresp;
  logic                  u_wcmd_valid, u_wcmd_ready, u_wvalid, u_wready, u_wdone;
  logic                  u_rcmd_valid, u_rcmd_ready, u_rvalid, u_rready, u_rlast, u_rerr;

  int checks = 0;
  int errors = 0;

  ami #(.MST_ID(TB_ID), .SLV_CHK(1'b1)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .u_wcmd_valid(u_wcmd_valid), .u_wcmd_ready(u_wcmd_ready), .u_wcmd_addr(u_wcmd_addr),
    .u_wcmd_len(u_wcmd_len), .u_wvalid(u_wvalid), .u_wready(u_wready), .u_wdata(u_wdata),
    .u_wstrb(u_wstrb), .u_wdone(u_wdone), .u_wresp(u_wresp),
    .u_rcmd_valid(u_rcmd_valid), .u_rcmd_ready(u_rcmd_ready), .u_rcmd_addr(u_rcmd_addr),
    .u_rcmd_len(u_rcmd_len), .u_rvalid(u_rvalid), .u_rready(u_rready), .u_rdata(u_rdata),
    .u_rresp(u_rresp), .u_rlast(u_rlast), .u_rerr(u_rerr)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Inputs change 1 ns after the rising edge; checks happen 1 ns later, well before the next edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
    ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
    u_wcmd_valid = 0; u_wcmd_addr = 0; u_wcmd_len = 0; u_wvalid = 0; u_wdata = 0; u_wstrb = 0;
    u_rcmd_valid = 0; u_rcmd_addr = 0; u_rcmd_len = 0; u_rready = 0;
    repeat (3) tick();
    #1;
    checks++; if (AWVALID !== 1'b0) begin errors++; $display("FAIL rst_awvalid got %b want 0", AWVALID); end
    checks++; if (WVALID !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %b want 0", WVALID); end
    checks++; if (BREADY !== 1'b0) begin errors++; $display("FAIL rst_bready got %b want 0", BREADY); end
    checks++; if (ARVALID !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %b want 0", ARVALID); end
    checks++; if (RREADY !== 1'b0) begin errors++; $display("FAIL rst_rready got %b want 0", RREADY); end
    checks++; if (u_wdone !== 1'b0) begin errors++; $display("FAIL rst_wdone got %b want 0", u_wdone); end
    checks++; if (u_rerr !== 1'b0) begin errors++; $display("FAIL rst_rerr got %b want 0", u_rerr); end
    checks++; if (u_wcmd_ready !== 1'b1) begin errors++; $display("FAIL rst_wcmd_ready got %b want 1", u_wcmd_ready); end
    checks++; if (u_rcmd_ready !== 1'b1) begin errors++; $display("FAIL rst_rcmd_ready got %b want 1", u_rcmd_ready); end
    checks++; if (AWADDR !== 32'h0) begin errors++; $display("FAIL rst_awaddr got %h want 0", AWADDR); end
    checks++; if (ARLEN !== 8'h0) begin errors++; $display("FAIL rst_arlen got %h want 0", ARLEN); end
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_write_basic();
    logic [AXI_DW-1:0] d [4];
    d[0] = 64'h1111_0000_0000_0001; d[1] = 64'h2222_0000_0000_0002;
    d[2] = 64'h3333_0000_0000_0003; d[3] = 64'h4444_0000_0000_0004;
    u_wcmd_valid = 1; u_wcmd_addr = 32'h104; u_wcmd_len = 8'd3;
    tick();
    u_wcmd_valid = 0; u_wvalid = 1; u_wdata = d[0]; u_wstrb = 8'hFF; WREADY = 1;
    #1;
    checks++; if (AWADDR !== 32'h100) begin errors++; $display("FAIL wr_awaddr got %h want 100", AWADDR); end
    checks++; if (AWLEN !== 8'd3) begin errors++; $display("FAIL wr_awlen got %0d want 3", AWLEN); end
    checks++; if (AWSIZE !== 3'd3) begin errors++; $display("FAIL wr_awsize got %0d want 3", AWSIZE); end
    checks++; if (AWBURST !== 2'b01) begin errors++; $display("FAIL wr_awburst got %b want 01", AWBURST); end
    checks++; if (AWID !== TB_ID) begin errors++; $display("FAIL wr_awid got %h want 5", AWID); end
    for (int c = 0; c < 2; c++) begin
      checks++; if (AWVALID !== 1'b1 || AWADDR !== 32'h100) begin errors++; $display("FAIL wr_aw_hold c%0d got v=%b a=%h want v=1 a=100", c, AWVALID, AWADDR); end
      checks++; if (WVALID !== 1'b0 || u_wready !== 1'b0) begin errors++; $display("FAIL wr_w_early c%0d got wvalid=%b uwready=%b want 0 0", c, WVALID, u_wready); end
      tick();
    end
    AWREADY = 1;
    tick();
    AWREADY = 0;
    for (int i = 0; i < 4; i++) begin
      u_wdata = d[i];
      #1;
      checks++; if (WVALID !== 1'b1 || WDATA !== d[i] || WSTRB !== 8'hFF) begin errors++; $display("FAIL wr_beat%0d got v=%b d=%h s=%h want v=1 d=%h s=ff", i, WVALID, WDATA, WSTRB, d[i]); end
      checks++; if (WLAST !== (i == 3)) begin errors++; $display("FAIL wr_wlast%0d got %b want %b", i, WLAST, (i == 3)); end
      tick();
    end
    u_wvalid = 0; WREADY = 0;
    #1;
    checks++; if (BREADY !== 1'b1 || WVALID !== 1'b0) begin errors++; $display("FAIL wr_resp_state got bready=%b wvalid=%b want 1 0", BREADY, WVALID); end
    BVALID = 1; BRESP = 2'b00;
    #1;
    checks++; if (u_wdone !== 1'b0) begin errors++; $display("FAIL wr_done_early got %b want 0", u_wdone); end
    tick();
    BVALID = 0;
    checks++; if (u_wdone !== 1'b1 || u_wresp !== 2'b00) begin errors++; $display("FAIL wr_done got %b resp %b want 1 00", u_wdone, u_wresp); end
    checks++; if (u_wcmd_ready !== 1'b1) begin errors++; $display("FAIL wr_idle got %b want 1", u_wcmd_ready); end
    tick();
    checks++; if (u_wdone !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got %b want 0", u_wdone); end
  endtask

  task automatic test_read_len0();
    u_rcmd_valid = 1; u_rcmd_addr = 32'h20C; u_rcmd_len = 8'd0;
    tick();
    u_rcmd_valid = 0; u_rready = 1;
    checks++; if (ARVALID !== 1'b1 || ARADDR !== 32'h208 || ARLEN !== 8'd0 || ARID !== TB_ID) begin errors++; $display("FAIL rd0_ar got v=%b a=%h l=%0d id=%h want 1 208 0 5", ARVALID, ARADDR, ARLEN, ARID); end
    checks++; if (RREADY !== 1'b0) begin errors++; $display("FAIL rd0_rready_early got %b want 0", RREADY); end
    ARREADY = 1;
    tick();
    ARREADY = 0;
    checks++; if (RREADY !== 1'b1 || u_rvalid !== 1'b0) begin errors++; $display("FAIL rd0_wait got rready=%b urvalid=%b want 1 0", RREADY, u_rvalid); end
    RVALID = 1; RLAST = 1; RDATA = 64'hDEAD_BEEF_0000_00AA; RRESP = 2'b00;
    #1;
    checks++; if (u_rvalid !== 1'b1 || u_rdata !== 64'hDEAD_BEEF_0000_00AA || u_rlast !== 1'b1) begin errors++; $display("FAIL rd0_beat got v=%b d=%h l=%b want 1 deadbeef000000aa 1", u_rvalid, u_rdata, u_rlast); end
    tick();
    RVALID = 0; RLAST = 0;
    #1;
    checks++; if (u_rcmd_ready !== 1'b1 || u_rvalid !== 1'b0 || RREADY !== 1'b0) begin errors++; $display("FAIL rd0_done got rdy=%b urvalid=%b rready=%b want 1 0 0", u_rcmd_ready, u_rvalid, RREADY); end
    checks++; if (u_rerr !== 1'b0) begin errors++; $display("FAIL rd0_rerr got %b want 0", u_rerr); end
  endtask

  task automatic test_read_short();
    u_rcmd_valid = 1; u_rcmd_addr = 32'h300; u_rcmd_len = 8'd3;
    tick();
    u_rcmd_valid = 0; ARREADY = 1;
    tick();
    ARREADY = 0; u_rready = 1; RVALID = 1; RLAST = 0; RDATA = 64'h1;
    tick();
    RLAST = 1; RDATA = 64'h2;
    #1;
    checks++; if (u_rerr !== 1'b0) begin errors++; $display("FAIL rds_rerr_early got %b want 0", u_rerr); end
    tick();
    RVALID = 0; RLAST = 0;
    #1;
    checks++; if (u_rerr !== 1'b1) begin errors++; $display("FAIL rds_rerr got %b want 1", u_rerr); end
    checks++; if (u_rcmd_ready !== 1'b1) begin errors++; $display("FAIL rds_idle got %b want 1", u_rcmd_ready); end
    tick();
    checks++; if (u_rerr !== 1'b1) begin errors++; $display("FAIL rds_sticky got %b want 1", u_rerr); end
  endtask

  task automatic test_gapped();
    logic [AXI_DW-1:0] d [3];
    logic [AXI_DW-1:0] got [3];
    logic              got_last [3];
    int idx = 0;
    d[0] = 64'hA0; d[1] = 64'hB1; d[2] = 64'hC2;
    u_wcmd_valid = 1; u_wcmd_addr = 32'h40; u_wcmd_len = 8'd2;
    tick();
    u_wcmd_valid = 0; u_wvalid = 1; u_wdata = d[0]; WREADY = 1;
    #1;
    checks++; if (WVALID !== 1'b0) begin errors++; $display("FAIL gap_w_before_aw got %b want 0", WVALID); end
    AWREADY = 1;
    tick();
    AWREADY = 0;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      WREADY   = (c % 2 == 1);
      u_wvalid = (c % 3 != 1);
      u_wdata  = d[idx];
      #1;
      checks++; if (WVALID !== u_wvalid || u_wready !== WREADY) begin errors++; $display("FAIL gap_pass c%0d got wvalid=%b uwready=%b want %b %b", c, WVALID, u_wready, u_wvalid, WREADY); end
      if (WVALID && WREADY) begin
        got[idx] = WDATA; got_last[idx] = WLAST; idx++;
      end
      tick();
    end
    u_wvalid = 0; WREADY = 0;
    checks++; if (idx != 3) begin errors++; $display("FAIL gap_timeout got %0d beats want 3", idx); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== d[i] || got_last[i] !== (i == 2)) begin errors++; $display("FAIL gap_order%0d got d=%h l=%b want d=%h l=%b", i, got[i], got_last[i], d[i], (i == 2)); end
    end
    BVALID = 1; BRESP = 2'b00;
    tick();
    BVALID = 0;
    checks++; if (u_wdone !== 1'b1) begin errors++; $display("FAIL gap_done got %b want 1", u_wdone); end
    tick();
  endtask

  task automatic test_simul();
    u_wcmd_valid = 1; u_wcmd_addr = 32'h500; u_wcmd_len = 8'd0;
    u_rcmd_valid = 1; u_rcmd_addr = 32'h600; u_rcmd_len = 8'd0;
    #1;
    checks++; if (u_wcmd_ready !== 1'b1 || u_rcmd_ready !== 1'b1) begin errors++; $display("FAIL sim_ready got w=%b r=%b want 1 1", u_wcmd_ready, u_rcmd_ready); end
    tick();
    u_wcmd_valid = 0; u_rcmd_valid = 0;
    checks++; if (AWVALID !== 1'b1 || ARVALID !== 1'b1) begin errors++; $display("FAIL sim_accept got aw=%b ar=%b want 1 1", AWVALID, ARVALID); end
    checks++; if (AWADDR !== 32'h500 || ARADDR !== 32'h600) begin errors++; $display("FAIL sim_addr got aw=%h ar=%h want 500 600", AWADDR, ARADDR); end
    AWREADY = 1; ARREADY = 1;
    tick();
    AWREADY = 0; ARREADY = 0;
    u_wvalid = 1; WREADY = 1; u_wdata = 64'h55; RVALID = 1; RLAST = 1; RDATA = 64'h66; u_rready = 1;
    #1;
    checks++; if (WLAST !== 1'b1 || u_rvalid !== 1'b1) begin errors++; $display("FAIL sim_beats got wlast=%b urvalid=%b want 1 1", WLAST, u_rvalid); end
    tick();
    u_wvalid = 0; WREADY = 0; RVALID = 0; RLAST = 0;
    checks++; if (u_rcmd_ready !== 1'b1) begin errors++; $display("FAIL sim_rd_idle got %b want 1", u_rcmd_ready); end
    BVALID = 1; BRESP = 2'b10;
    tick();
    BVALID = 0; BRESP = 2'b00;
    checks++; if (u_wdone !== 1'b1 || u_wresp !== 2'b10) begin errors++; $display("FAIL sim_bresp got done=%b resp=%b want 1 10", u_wdone, u_wresp); end
    tick();
  endtask

  task automatic test_reset_mid();
    u_wcmd_valid = 1; u_wcmd_addr = 32'h80; u_wcmd_len = 8'd3;
    tick();
    u_wcmd_valid = 0; AWREADY = 1;
    tick();
    AWREADY = 0; u_wvalid = 1; WREADY = 1; u_wdata = 64'h1;
    tick();
    WREADY = 0; u_wdata = 64'h2;
    #1;
    checks++; if (WVALID !== 1'b1 || WLAST !== 1'b0) begin errors++; $display("FAIL rm_beat2 got wvalid=%b wlast=%b want 1 0", WVALID, WLAST); end
    ARESET = 1;
    tick();
    checks++; if (AWVALID !== 1'b0 || WVALID !== 1'b0 || BREADY !== 1'b0 || ARVALID !== 1'b0 || RREADY !== 1'b0) begin errors++; $display("FAIL rm_valids got aw=%b w=%b b=%b ar=%b r=%b want 0", AWVALID, WVALID, BREADY, ARVALID, RREADY); end
    checks++; if (u_wcmd_ready !== 1'b1) begin errors++; $display("FAIL rm_wcmd_ready got %b want 1", u_wcmd_ready); end
    checks++; if (u_rerr !== 1'b0) begin errors++; $display("FAIL rm_rerr got %b want 0", u_rerr); end
    ARESET = 0; u_wvalid = 0; BVALID = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (u_wdone !== 1'b0 || WVALID !== 1'b0) begin errors++; $display("FAIL rm_no_done c%0d got done=%b wvalid=%b want 0 0", c, u_wdone, WVALID); end
    end
    BVALID = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_len0();
    test_read_short();
    test_gapped();
    test_simul();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
